// File: rtl/mbe_txn_master.sv
// rtl/mbe_txn_master.sv - stimulus/scoreboard master for the MBE multiplier wrapper
// Issues one operand pair at a time, checks the returned signed product, counts results and mismatches.
module mbe_txn_master #(
  parameter int          WIDTH = 32,
  parameter logic [31:0] SEED  = 32'hACE1_2468,
  parameter bit          BP_EN = 1'b0,
  parameter int          CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_txn,
  input  logic               use_ext,
  input  logic [WIDTH-1:0]   ext_a,
  input  logic [WIDTH-1:0]   ext_b,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic               in_valid,
  input  logic               in_ready,
  input  logic [2*WIDTH-1:0] out_data,
  input  logic               out_valid,
  output logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [WIDTH-1:0]   last_err_a,
  output logic [WIDTH-1:0]   last_err_b
);

  localparam int LW = 2 * WIDTH;
  localparam logic [LW-1:0] SEED_W = LW'(SEED);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRIVE,
    S_WAIT_RSP,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    lfsr_q, lfsr_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [LW-1:0]    exp_q, exp_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] txn_q, txn_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] lea_q, lea_d, leb_q, leb_d;

  logic [WIDTH-1:0] a_sel, b_sel;
  logic [LW-1:0]    a_ext, b_ext;
  logic             accept;

  // One LFSR step per call; taps 64,63,61,60 give a maximal sequence at WIDTH=32.
  function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] v);
    return {v[LW-2:0], v[LW-1] ^ v[LW-2] ^ v[LW-4] ^ v[LW-5]};
  endfunction

  assign a_sel = use_ext ? ext_a : lfsr_q[LW-1:WIDTH];
  assign b_sel = use_ext ? ext_b : lfsr_q[WIDTH-1:0];
  assign a_ext = {{WIDTH{a_sel[WIDTH-1]}}, a_sel};
  assign b_ext = {{WIDTH{b_sel[WIDTH-1]}}, b_sel};

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    a_d       = a_q;
    b_d       = b_q;
    exp_d     = exp_q;
    rem_d     = rem_q;
    txn_d     = txn_q;
    err_d     = err_q;
    lea_d     = lea_q;
    leb_d     = leb_q;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = num_txn;
          txn_d   = '0;
          err_d   = '0;
          lfsr_d  = SEED_W;
          state_d = (num_txn == '0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: begin
        busy    = 1'b1;
        a_d     = a_sel;
        b_d     = b_sel;
        exp_d   = $signed(a_ext) * $signed(b_ext);
        lfsr_d  = lfsr_step(lfsr_q);
        state_d = S_DRIVE;
      end
      S_DRIVE: begin
        busy     = 1'b1;
        in_valid = 1'b1;
        if (in_ready) state_d = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        busy      = 1'b1;
        out_ready = BP_EN ? lfsr_q[0] : 1'b1;
        if (BP_EN) lfsr_d = lfsr_step(lfsr_q);
        accept = out_valid && out_ready;
        if (accept) begin
          txn_d = (&txn_q) ? txn_q : txn_q + CNT_W'(1);
          if (out_data != exp_q) begin
            err_d = (&err_q) ? err_q : err_q + CNT_W'(1);
            lea_d = a_q;
            leb_d = b_q;
          end
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? S_FINISH : S_LOAD;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_W;
      a_q     <= '0;
      b_q     <= '0;
      exp_q   <= '0;
      rem_q   <= '0;
      txn_q   <= '0;
      err_q   <= '0;
      lea_q   <= '0;
      leb_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      txn_q   <= txn_d;
      err_q   <= err_d;
      lea_q   <= lea_d;
      leb_q   <= leb_d;
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign txn_count  = txn_q;
  assign err_count  = err_q;
  assign last_err_a = lea_q;
  assign last_err_b = leb_q;

endmodule
